// File: rtl/conv2d_arbiter_if.sv
// conv2d_arbiter_if: requester/engine handshake bundle between the requesters, the conv2d engine and the arbiter
interface conv2d_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = 2,
  parameter int CNT_W   = 16
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] req_done;
  logic [NUM_REQ-1:0] req_err;
  logic [SEL_W-1:0]   eng_sel;
  logic               eng_rst;
  logic               eng_done;
  logic               busy;
  logic [CNT_W-1:0]   last_cycles;
  modport master (
    output req, eng_done,
    input  gnt, eng_sel, eng_rst, req_done, req_err, busy, last_cycles
  );
  modport slave (
    input  req, eng_done,
    output gnt, eng_sel, eng_rst, req_done, req_err, busy, last_cycles
  );
endinterface

// File: rtl/conv2d_arbiter.sv
// conv2d_arbiter: round-robin sharing of one conv2d engine, with engine restart, stale-done blanking and a per-job timeout
module conv2d_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = 2,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
)(
  input logic clk,
  input logic rst,
  conv2d_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LAUNCH, BUSY, DONE, ABORT} state_t;
  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d, sel_q, sel_d, pick, idx;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, last_q, last_d, cnt_inc;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  // scan downward so the requester closest above ptr overwrites the others
  always_comb begin
    pick = ptr_q;
    idx  = ptr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = SEL_W'((int'(ptr_q) + i) % NUM_REQ);
      if (bus.req[idx]) pick = idx;
    end
  end
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: if (|bus.req) begin
        gnt_d   = NUM_REQ'(1) << pick;
        sel_d   = pick;
        state_d = LAUNCH;
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = BUSY;
      end
      // cnt_q == 0 marks the first BUSY cycle, where a leftover done is blanked
      BUSY: begin
        cnt_d = cnt_inc;
        if (bus.eng_done && cnt_q != '0) begin
          state_d = DONE;
          last_d  = cnt_inc;
        end else if (cnt_inc >= CNT_W'(TIMEOUT - 1)) begin
          state_d = ABORT;
          last_d  = cnt_inc;
        end
      end
      DONE, ABORT: begin
        ptr_d   = (sel_q == SEL_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.gnt         = gnt_q;
  assign bus.eng_sel     = sel_q;
  assign bus.eng_rst     = state_q == LAUNCH;
  assign bus.busy        = state_q != IDLE;
  assign bus.req_done    = (state_q == DONE) ? gnt_q : '0;
  assign bus.req_err     = (state_q == ABORT) ? gnt_q : '0;
  assign bus.last_cycles = last_q;
endmodule

// File: tb/tb_conv2d_arbiter.sv
// tb_conv2d_arbiter: directed and randomized jobs against a job-level model of arbitration order and completion timing
module tb_conv2d_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;
  localparam int CW = 16;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   ncomp = 0, nfail = 0;
  int   dly = 1000, ecnt = 0, ptr_m = 0;
  bit   force_done = 1'b0;
  int   mbox [N][4];
  always #5 clk = ~clk;
  conv2d_arbiter_if #(.NUM_REQ(N), .SEL_W(2), .CNT_W(CW)) bus ();
  conv2d_arbiter #(.NUM_REQ(N), .SEL_W(2), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  // engine model: done rises dly cycles after the cycle in which eng_rst was high, and stays up
  always @(posedge clk or negedge rst)
    if (!rst) ecnt <= 0;
    else if (bus.eng_rst) ecnt <= 1;
    else if (ecnt != 0 && ecnt < 10000) ecnt <= ecnt + 1;
  assign bus.eng_done = force_done || (ecnt != 0 && ecnt >= dly);
  function automatic int conv(int k);
    int s = 0;
    for (int ch = 0; ch < 2; ch++)
      for (int ky = 0; ky < 2; ky++)
        for (int kx = 0; kx < 2; kx++)
          s += ch * 8 + (2 * (k / 2) + ky) * 4 + 2 * (k % 2) + kx;
    return s;
  endfunction
  // result routed to whichever requester eng_sel names when the job completes
  always @(posedge clk)
    if (bus.req_done != '0)
      for (int k = 0; k < 4; k++) mbox[bus.eng_sel][k] <= conv(k);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic int pick(logic [N-1:0] r, int p);
    for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
    return 0;
  endfunction
  task automatic run_job(input logic [N-1:0] r, input int d, input bit drop);
    int w, exp_c, n;
    bit err;
    bus.req = r;
    dly     = d;
    w       = pick(r, ptr_m);
    exp_c   = (force_done || d < 2) ? 2 : d;
    err     = exp_c > TO - 1;
    if (err) exp_c = TO - 1;
    n = 0;
    do begin tick; n++; end while (!bus.eng_rst && n < 20);
    chk("launch_latency", n, 1);
    chk("gnt", bus.gnt, 1 << w);
    chk("eng_sel", bus.eng_sel, w);
    chk("busy", bus.busy, 1);
    if (drop) bus.req = '0;
    n = 0;
    do begin
      tick;
      n++;
      if (n == 1) chk("eng_rst_single", bus.eng_rst, 0);
    end while (bus.req_done == '0 && bus.req_err == '0 && n < 40);
    chk("busy_cycles", n - 1, exp_c);
    chk(err ? "req_err" : "req_done", err ? bus.req_err : bus.req_done, 1 << w);
    chk("other_pulse", err ? bus.req_done : bus.req_err, 0);
    chk("gnt_hold", bus.gnt, 1 << w);
    chk("last_cycles", bus.last_cycles, exp_c);
    ptr_m = (w + 1) % N;
    tick;
    chk("idle_gnt", bus.gnt, 0);
    chk("idle_busy", bus.busy, 0);
    chk("pulses_clear", {bus.req_done, bus.req_err}, 0);
  endtask
  initial begin
    logic [N-1:0] r;
    bus.req = '0;
    tick;
    tick;
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_eng_rst", bus.eng_rst, 0);
    chk("rst_sel", bus.eng_sel, 0);
    chk("rst_last", bus.last_cycles, 0);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("rr_order", pick(4'b1111, ptr_m), i % N);
      run_job(4'b1111, 2 + i, 1'b0);
    end
    run_job(4'b0010, 10, 1'b0);
    for (int k = 0; k < 4; k++) chk("conv_out", mbox[1][k], (k == 0) ? 52 : (k == 1) ? 68 : (k == 2) ? 116 : 132);
    run_job(4'b1000, 5, 1'b1);
    force_done = 1'b1;
    run_job(4'b0100, 50, 1'b0);
    force_done = 1'b0;
    run_job(4'b0001, 100, 1'b0);
    run_job(4'b0001, 15, 1'b0);
    run_job(4'b0001, 16, 1'b0);
    run_job(4'b0110, 0, 1'b0);
    run_job(4'b0110, 2, 1'b0);
    for (int j = 0; j < 30; j++) begin
      r = N'($urandom_range(0, 15));
      if (r == '0) begin
        bus.req = '0;
        for (int k = 0; k < 3; k++) begin tick; chk("no_req_idle", bus.busy, 0); end
      end else run_job(r, int'($urandom_range(0, 18)), 1'($urandom_range(0, 1)));
    end
    run_job(4'b0100, 5, 1'b0);
    bus.req = 4'b0010;
    dly     = 8;
    tick;
    tick;
    tick;
    chk("pre_rst_busy", bus.busy, 1);
    rst = 1'b0;
    #1;
    chk("async_rst_outs", {bus.gnt, bus.eng_sel, bus.eng_rst, bus.busy, bus.req_done, bus.req_err}, 0);
    chk("async_rst_last", bus.last_cycles, 0);
    bus.req = '0;
    for (int k = 0; k < 3; k++) begin tick; chk("rst_no_pulse", {bus.req_done, bus.req_err, bus.busy}, 0); end
    rst   = 1'b1;
    ptr_m = 0;
    run_job(4'b1111, 4, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule
